// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit positions and
// the active-low hex glyph table (dp bit off).
package seg_pkg;

  typedef enum logic [2:0] {
    SEG_A  = 3'd0,
    SEG_B  = 3'd1,
    SEG_C  = 3'd2,
    SEG_D  = 3'd3,
    SEG_E  = 3'd4,
    SEG_F  = 3'd5,
    SEG_G  = 3'd6,
    SEG_DP = 3'd7
  } seg_bit_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Entry n is the glyph for nibble n; listed F down to 0 so index 0 is the LSB slot.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-low a..g pattern lookup.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);

  assign seg_n = HEX_SEG[nib][SEG_G:SEG_A];

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode hex display driver with frame-aligned double
// buffering, leading-zero blanking, per-digit decimal point and blink.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int CLK_HZ       = 20_000_000,
  parameter int SCAN_HZ      = 1200,
  parameter int DEAD         = 2,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  blank_lz,
  input  logic                  load,
  output logic                  pend,
  output logic                  frame_done,
  output logic [7:0]            seg_n,
  output logic [DIGITS-1:0]     dig_n
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = $clog2(DIGITS);
  localparam int BW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic                  tick;
  logic                  boundary;
  logic [4*DIGITS-1:0]   act_data, pnd_data;
  logic [DIGITS-1:0]     act_dp, pnd_dp, act_blink, pnd_blink;
  logic [BW-1:0]         bcnt;
  logic                  phase;
  logic [DIGITS-1:0]     lz_zero;
  logic                  lz_acc;
  logic [3:0]            nib;
  logic [6:0]            hex_n;
  logic                  dark, lz_blank, bl_blank;
  logic [7:0]            seg_nxt;
  logic [DIGITS-1:0]     dig_nxt;
  logic [7:0]            seg_p1;
  logic [DIGITS-1:0]     dig_p1;
  logic                  fd_p1;

  assign tick     = (presc == PW'(DIV - 1));
  assign boundary = tick && (idx == IW'(DIGITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= boundary ? '0 : idx + 1'b1;
    end
  end

  // A load landing on the boundary bypasses the pending shadow entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_data  <= '0;
      act_dp    <= '0;
      act_blink <= '0;
      pnd_data  <= '0;
      pnd_dp    <= '0;
      pnd_blink <= '0;
      pend      <= 1'b0;
    end else if (load && boundary) begin
      act_data  <= data;
      act_dp    <= dp;
      act_blink <= blink_mask;
      pend      <= 1'b0;
    end else if (load) begin
      pnd_data  <= data;
      pnd_dp    <= dp;
      pnd_blink <= blink_mask;
      pend      <= 1'b1;
    end else if (boundary && pend) begin
      act_data  <= pnd_data;
      act_dp    <= pnd_dp;
      act_blink <= pnd_blink;
      pend      <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (boundary) begin
      if (bcnt == BW'(BLINK_FRAMES - 1)) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  // lz_zero[i] is set when nibbles i..DIGITS-1 are all zero.
  always_comb begin
    lz_zero = '0;
    lz_acc  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_acc     = lz_acc & (act_data[4*i +: 4] == 4'h0);
      lz_zero[i] = lz_acc;
    end
  end

  assign nib = act_data[{idx, 2'b00} +: 4];

  seg_hex_decode u_dec (
    .nib   (nib),
    .seg_n (hex_n)
  );

  always_comb begin
    dark     = (presc < PW'(DEAD));
    lz_blank = blank_lz && (idx != '0) && lz_zero[idx];
    bl_blank = phase && act_blink[idx];
    seg_nxt  = SEG_BLANK;
    dig_nxt  = '1;
    if (!dark) begin
      dig_nxt = ~(DIGITS'(1) << idx);
      if (bl_blank) begin
        seg_nxt = SEG_BLANK;
      end else if (lz_blank) begin
        seg_nxt[SEG_DP] = ~act_dp[idx];
      end else begin
        seg_nxt = {~act_dp[idx], hex_n};
      end
    end
  end

  // Stage p1: registered pin drive, one cycle behind prescaler/idx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_p1 <= SEG_BLANK;
      dig_p1 <= '1;
      fd_p1  <= 1'b0;
    end else begin
      seg_p1 <= seg_nxt;
      dig_p1 <= dig_nxt;
      fd_p1  <= boundary;
    end
  end

  assign seg_n      = seg_p1;
  assign dig_n      = dig_p1;
  assign frame_done = fd_p1;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with a frame-level reference model checked every cycle.
module tb_seg_scan_mux;

  localparam int DIGITS       = 4;
  localparam int DIV          = 10;
  localparam int DEAD         = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = DIV * DIGITS;

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  blink_mask;
  logic        blank_lz;
  logic        load;
  logic        pend;
  logic        frame_done;
  logic [7:0]  seg_n;
  logic [3:0]  dig_n;

  int pass_cnt = 0;
  int total    = 0;
  bit chk_en   = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_scan_mux #(
    .DIGITS       (DIGITS),
    .CLK_HZ       (1000),
    .SCAN_HZ      (100),
    .DEAD         (DEAD),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .dp         (dp),
    .blink_mask (blink_mask),
    .blank_lz   (blank_lz),
    .load       (load),
    .pend       (pend),
    .frame_done (frame_done),
    .seg_n      (seg_n),
    .dig_n      (dig_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // What digit d must show for a given frame's active contents.
  function automatic logic [7:0] model_seg(input int d, input logic [15:0] dat,
                                           input logic [3:0] dpv, input logic [3:0] bm,
                                           input bit lz_en, input bit ph);
    logic [3:0] n;
    bit upper_zero;
    logic [7:0] g;
    n = dat[d*4 +: 4];
    upper_zero = 1;
    for (int j = d; j < DIGITS; j++) if (dat[j*4 +: 4] != 4'h0) upper_zero = 0;
    if (ph && bm[d]) return 8'hFF;
    if (lz_en && d != 0 && upper_zero) return dpv[d] ? 8'h7F : 8'hFF;
    g = hex_tab[n];
    return {~dpv[d], g[6:0]};
  endfunction

  int          k;
  int          pos, dsel, fr;
  bit          bnd;
  logic [15:0] m_data, p_data;
  logic [3:0]  m_dp, p_dp, m_bm, p_bm;
  bit          m_pend;
  logic [7:0]  e_seg;
  logic [3:0]  e_dig;
  bit          e_fd, e_pend;

  // Reference: edge k after reset shows dwell slot (k-1) of the scan timeline.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = 0; m_data = 0; p_data = 0; m_dp = 0; p_dp = 0; m_bm = 0; p_bm = 0; m_pend = 0;
      e_seg = 8'hFF; e_dig = 4'hF; e_fd = 0; e_pend = 0;
    end else begin
      k    = k + 1;
      pos  = (k - 1) % DIV;
      dsel = ((k - 1) / DIV) % DIGITS;
      fr   = (k - 1) / FRAME;
      if (pos < DEAD) begin
        e_seg = 8'hFF;
        e_dig = 4'hF;
      end else begin
        e_dig = 4'hF ^ (4'b0001 << dsel);
        e_seg = model_seg(dsel, m_data, m_dp, m_bm, blank_lz, ((fr / BLINK_FRAMES) % 2) == 1);
      end
      bnd  = (k % FRAME) == 0;
      e_fd = bnd;
      if (load && bnd) begin
        m_data = data; m_dp = dp; m_bm = blink_mask; m_pend = 0;
      end else if (load) begin
        p_data = data; p_dp = dp; p_bm = blink_mask; m_pend = 1;
      end else if (bnd && m_pend) begin
        m_data = p_data; m_dp = p_dp; m_bm = p_bm; m_pend = 0;
      end
      e_pend = m_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_seg_n", seg_n, e_seg);
      check("cyc_dig_n", dig_n, e_dig);
      check("cyc_frame_done", frame_done, e_fd);
      check("cyc_pend", pend, e_pend);
    end
  end

  task automatic get_digit(input string nm, input int d, output logic [7:0] s, output bit ok);
    ok = 0;
    s  = 8'hxx;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (dig_n === (4'hF ^ (4'b0001 << d))) begin
        ok = 1;
        s  = seg_n;
      end
    end
    if (!ok) begin
      total++;
      $display("FAIL %s: enable for digit %0d never seen, dig_n=%h", nm, d, dig_n);
    end
  endtask

  task automatic expect_digit(input string nm, input int d, input logic [7:0] e);
    logic [7:0] s;
    bit ok;
    get_digit(nm, d, s, ok);
    if (ok) check(nm, s, e);
  endtask

  task automatic wait_fd(input string nm);
    bit ok;
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (frame_done === 1'b1) ok = 1;
    end
    if (!ok) begin
      total++;
      $display("FAIL %s: frame_done never pulsed", nm);
    end
  endtask

  task automatic load_pulse(input logic [15:0] dv, input logic [3:0] dpv, input logic [3:0] bm);
    data = dv; dp = dpv; blink_mask = bm; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  logic [7:0] s5 [4];
  bit         ok5;
  int         period;

  initial begin
    rst = 1'b1; load = 1'b0; data = '0; dp = '0; blink_mask = '0; blank_lz = 1'b0;
    @(posedge clk);
    #1 chk_en = 1;
    @(negedge clk);
    check("rst_seg_n", seg_n, 8'hFF);
    check("rst_dig_n", dig_n, 4'hF);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_pend", pend, 1'b0);
    rst = 1'b0;

    // Scan order and frame period with cleared data
    expect_digit("t1_d0", 0, 8'hC0);
    expect_digit("t1_d1", 1, 8'hC0);
    expect_digit("t1_d2", 2, 8'hC0);
    expect_digit("t1_d3", 3, 8'hC0);
    wait_fd("t1_fd");
    period = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      period++;
      if (frame_done === 1'b1) break;
    end
    check("t1_period", period, 40);

    // Double buffer: mid-frame load waits for the boundary
    repeat (5) @(negedge clk);
    load_pulse(16'h1234, 4'h0, 4'h0);
    check("t2_pend_set", pend, 1'b1);
    wait_fd("t2_fd");
    check("t2_pend_clr", pend, 1'b0);
    expect_digit("t2_d0", 0, 8'h99);
    expect_digit("t2_d1", 1, 8'hB0);
    expect_digit("t2_d2", 2, 8'hA4);
    expect_digit("t2_d3", 3, 8'hF9);

    // Last load wins
    wait_fd("t3_fd0");
    repeat (5) @(negedge clk);
    data = 16'hAAAA; load = 1'b1;
    @(negedge clk);
    data = 16'h5555;
    @(negedge clk);
    load = 1'b0;
    wait_fd("t3_fd1");
    expect_digit("t3_d0", 0, 8'h92);
    expect_digit("t3_d1", 1, 8'h92);
    expect_digit("t3_d2", 2, 8'h92);
    expect_digit("t3_d3", 3, 8'h92);

    // Load coincident with the boundary tick
    for (int n = 0; n < 100 && ((k + 1) % FRAME) != 0; n++) @(negedge clk);
    load_pulse(16'h0F0F, 4'h0, 4'h0);
    check("t3_coinc_pend", pend, 1'b0);
    check("t3_coinc_fd", frame_done, 1'b1);
    expect_digit("t3_c0", 0, 8'h8E);
    expect_digit("t3_c1", 1, 8'hC0);
    expect_digit("t3_c2", 2, 8'h8E);
    expect_digit("t3_c3", 3, 8'hC0);

    // Leading-zero blanking
    repeat (3) @(negedge clk);
    blank_lz = 1'b1;
    load_pulse(16'h0040, 4'b0100, 4'h0);
    wait_fd("t4_fd0");
    expect_digit("t4_d0", 0, 8'hC0);
    expect_digit("t4_d1", 1, 8'h99);
    expect_digit("t4_d2", 2, 8'h7F);
    expect_digit("t4_d3", 3, 8'hFF);
    load_pulse(16'h0000, 4'h0, 4'h0);
    wait_fd("t4_fd1");
    expect_digit("t4_z0", 0, 8'hC0);
    expect_digit("t4_z1", 1, 8'hFF);
    expect_digit("t4_z2", 2, 8'hFF);
    expect_digit("t4_z3", 3, 8'hFF);

    // Blink on digit 0 only
    blank_lz = 1'b0;
    load_pulse(16'h0008, 4'b0001, 4'b0001);
    wait_fd("t5_fd0");
    for (int f = 0; f < 4; f++) begin
      get_digit("t5_get", 0, s5[f], ok5);
      if (f == 0) expect_digit("t5_d1", 1, 8'hC0);
      wait_fd("t5_fdn");
    end
    check("t5_s0_is_glyph", (s5[0] == 8'h00) || (s5[0] == 8'hFF), 1'b1);
    check("t5_alt02", s5[0] ^ s5[2], 8'hFF);
    check("t5_alt13", s5[1] ^ s5[3], 8'hFF);

    // Asynchronous reset between clock edges
    expect_digit("t6_pre", 2, 8'hC0);
    #2 rst = 1'b1;
    #1;
    check("t6_async_seg", seg_n, 8'hFF);
    check("t6_async_dig", dig_n, 4'hF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_dead0", dig_n, 4'hF);
    @(negedge clk);
    check("t6_dead1", dig_n, 4'hF);
    @(negedge clk);
    check("t6_first_dig", dig_n, 4'hE);
    check("t6_first_seg", seg_n, 8'hC0);
    expect_digit("t6_d3", 3, 8'hC0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Parametrised time-multiplexed hex display driver for common-anode 7-segment banks of DIGITS digits. It scans one digit at a time at a programmable dwell rate and adds per-digit decimal points, leading-zero blanking and per-digit blink. New values are double-buffered and applied only at frame boundaries, so a refresh never shows a mix of old and new data. It sits between register/status logic and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned (2..8)
CLK_HZ, 20_000_000, input clock frequency in Hz
SCAN_HZ, 1200, digit switch rate in Hz; localparam DIV = CLK_HZ/SCAN_HZ clock cycles per digit
DEAD, 2, cycles at the start of each dwell with all digits off (anti-ghosting); DIV >= DEAD+2 is required
BLINK_FRAMES, 128, frames per blink half-period

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
data  in  4*DIGITS  hex nibbles; nibble i = digit i, digit 0 = rightmost
dp  in  DIGITS  decimal point request per digit
blink_mask  in  DIGITS  1 = digit blinks
blank_lz  in  1  leading-zero blanking enable (level, sampled every cycle)
load  in  1  one-cycle strobe that captures data/dp/blink_mask
pend  out  1  captured value is waiting for the next frame boundary
frame_done  out  1  one-cycle pulse at each frame boundary
seg_n  out  8  active-low segments; bit0=a..bit6=g, bit7=dp
dig_n  out  DIGITS  active-low digit enables

Behaviour:
- Reset (async, immediate): prescaler=0, idx=0, active and pending shadows=0, pend=0, blink phase=0, blink frame counter=0, seg_n=8'hFF, dig_n=all ones, frame_done=0.
- Prescaler counts 0..DIV-1. tick is asserted when prescaler==DIV-1; the prescaler wraps to 0 on the same edge.
- On tick, idx advances by 1. When idx==DIGITS-1, idx wraps to 0 and that cycle is the frame boundary.
- frame_done is registered and is high for exactly the one cycle after a boundary tick.
- Double buffer:
  - load without a boundary on the same cycle: pending <= inputs, pend <= 1. A second load while pend=1 overwrites pending; the last load wins.
  - Boundary with pend=1: active <= pending, pend <= 0.
  - load and boundary on the same cycle: inputs go directly to active; pend <= 0; any older pending value is discarded.
- Blink: a frame counter runs 0..BLINK_FRAMES-1. At each wrap, phase toggles.
- Per-digit output computation for digit i = idx:
  - LZ-blank: blank_lz=1, i≠0, and active nibbles i..DIGITS-1 are all zero. The segments are dark; dp still shows if set.
  - Blink-blank: phase=1 and blink_mask[i]=1. The whole digit is dark, including dp.
  - Otherwise: seg_n = decoded nibble, with bit7 = ~dp[i].
- Outputs are registered, one cycle behind prescaler/idx.
  - While prescaler < DEAD: dig_n = all ones, seg_n = 8'hFF.
  - Otherwise: dig_n = ~(1<<idx).
- At most one dig_n bit is ever low.
- Digit 0 is never LZ-blanked, so zero data shows "0".
- Encoding of 0..F (active-low, dp off): C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.

Decomposition:
- Package seg_pkg:
  - 16-entry hex segment constant table (values above)
  - SEG_BLANK = 8'hFF
  - segment bit-position constants
- Sub-module seg_hex_decode: combinational 4-bit nibble -> 7-bit active-low pattern, using the seg_pkg table. Instantiate once, fed by the mux on idx.
- All counters, shadows and blink logic stay in seg_scan_mux.

Test Plan:
(Bench override: CLK_HZ=1000, SCAN_HZ=100 -> DIV=10, DEAD=2, BLINK_FRAMES=2, DIGITS=4.)
1. Scan order: rst pulse, then no load -> digit 0 shows seg_n=C0 and digits 1..3 show C0. Each dig_n enable lasts 8 cycles after 2 dark cycles; order is E,D,B,7 repeating; frame_done pulses every 40 cycles.
2. Double buffer: load data=16'h1234 mid-frame -> pend=1 until the boundary. The next frame shows digits 0..3 = 99,B0,A4,F9; no digit of the old value appears after the boundary; pend=0.
3. Last-load-wins and coincident load: load 16'hAAAA, then 16'h5555 before the boundary -> 92 on all digits. Then load 16'h0F0F exactly on a boundary tick -> it is active in the immediately following frame and pend stays 0.
4. Leading-zero blanking: data=16'h0040, blank_lz=1, dp=4'b0100 -> digit3 seg_n=FF, digit2 seg_n=7F (dp only), digit1=99, digit0=C0. With data=0, digit0 shows C0 and digits 1..3 show FF.
5. Blink: blink_mask=4'b0001, dp[0]=1, data=8 -> digit0 alternates 00 / FF every 2 frames; digits 1..3 are unaffected.
6. Reset mid-dwell: assert rst asynchronously between clock edges -> seg_n=FF and dig_n=F immediately. After release, the scan restarts at digit 0 with a DEAD gap, and the previously loaded data is cleared (digits show C0).
